// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the PE input-FIFO read controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: DATA_W stream/FIFO width, SKID_DEPTH capture-buffer size, state_e encoding.
package fifo_pkg;

    localparam int DATA_W     = 16;
    // Two entries absorb the one-cycle FIFO read latency without bubbles.
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register FIFO capturing FIFO dataOut words ahead of the output stream.
// Latency: a word pushed on an edge is at the head the following cycle.
// Backpressure: caller guarantees no push when full; pop on empty is ignored.
// Ports: Clk/Rst clock and async active-low reset; clr_i synchronous clear;
//        push_i/push_dat_i write side; pop_i removes head; count_o occupancy; head_o oldest word.
module skid_buf2
    import fifo_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              pop_ok;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        count_d  = count_q;
        pop_ok   = pop_i && (count_q != 2'd0);
        if (clr_i) begin
            mem_d[0] = '0;
            mem_d[1] = '0;
            count_d  = 2'd0;
        end else begin
            // Pop first, then push into the first free slot, so a
            // simultaneous push/pop keeps occupancy unchanged.
            if (pop_ok) begin
                mem_d[0] = mem_q[1];
                mem_d[1] = '0;
                count_d  = count_q - 2'd1;
            end
            if (push_i && (count_d != 2'd2)) begin
                mem_d[count_d[0]] = push_dat_i;
                count_d           = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/fifo_reader_16b.sv
// Read-side controller: strobes FIFO RD, captures dataOut a cycle later, streams words out.
// Latency: fifo_rd one cycle after start; word reaches out_data one cycle after its capture edge.
// Backpressure: out_ready low stops RD once the skid plus in-flight word would fill it.
// Ports: Clk, Rst (async active-low), EN enable, start/len burst request, flush abort,
//        fifo_empty/fifo_data/fifo_rd FIFO side, out_data/out_valid/out_ready stream,
//        busy (not IDLE), done (one-cycle end-of-burst pulse).
module fifo_reader_16b
    import fifo_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              EN,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  delivered_q, delivered_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              rd_q, rd_d;
    logic [1:0]        skid_cnt;
    logic [DATA_W-1:0] skid_head;
    logic              hs;
    logic [2:0]        occ;

    skid_buf2 u_skid (
        .Clk        (Clk),
        .Rst        (Rst),
        .clr_i      (flush),
        .push_i     (rd_q),
        .push_dat_i (fifo_data),
        .pop_i      (hs),
        .count_o    (skid_cnt),
        .head_o     (skid_head)
    );

    assign out_valid = (skid_cnt != 2'd0) && EN;
    assign out_data  = skid_head;
    assign hs        = out_valid && out_ready;

    // Occupancy the skid will have after this edge, counting the word already
    // in flight and crediting the head leaving now; this is what lets RD run
    // every cycle while the stream drains.
    assign occ = {1'b0, skid_cnt} + {2'b00, rd_q} - {2'b00, hs};

    assign fifo_rd = EN && (state_q == RUN) && !fifo_empty
                     && (issued_q < len_q) && (occ < 3'(SKID_DEPTH));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            issued_q    <= '0;
            delivered_q <= '0;
            len_q       <= '0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            len_q       <= len_d;
            rd_q        <= rd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        len_d       = len_q;
        rd_d        = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            issued_d    = '0;
            delivered_d = '0;
            len_d       = '0;
        end else begin
            // fifo_rd and hs are already gated by EN, so counters freeze with it.
            rd_d = fifo_rd;
            if (fifo_rd) issued_d = issued_q + LEN_W'(1);
            if (hs)      delivered_d = delivered_q + LEN_W'(1);
            unique case (state_q)
                IDLE: begin
                    if (start && EN) begin
                        len_d       = len;
                        issued_d    = '0;
                        delivered_d = '0;
                        state_d     = (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (hs && (delivered_q + LEN_W'(1) == len_q)) state_d = DONE;
                end
                DONE: begin
                    if (EN) begin
                        state_d     = IDLE;
                        issued_d    = '0;
                        delivered_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

endmodule

// File: tb/tb_fifo_reader_16b.sv
module tb_fifo_reader_16b;

    logic        Clk;
    logic        Rst;
    logic        EN;
    logic        start;
    logic [7:0]  len;
    logic        flush;
    logic        fifo_empty;
    logic [15:0] fifo_data;
    logic        fifo_rd;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    fifo_reader_16b #(.LEN_W(8)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .EN         (EN),
        .start      (start),
        .len        (len),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // FIFO model: registered dataOut, updated on an RD edge.
    logic [15:0] fmem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    initial fifo_data = 16'h0000;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge Clk) begin
        if (fifo_rd) begin
            fifo_data <= fmem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] rd_v, vld_v, done_v, busy_v;
    logic [15:0] dat_v [0:31];
    logic [15:0] acc [$];
    logic [15:0] exp_w [0:7];

    task automatic fpush(input logic [15:0] v);
        fmem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic clr_rec();
        rd_v = '0; vld_v = '0; done_v = '0; busy_v = '0;
        for (int i = 0; i < 32; i++) dat_v[i] = '0;
        acc.delete();
    endtask

    task automatic sample(input int c);
        @(negedge Clk);
        rd_v[c]   = fifo_rd;
        vld_v[c]  = out_valid;
        done_v[c] = done;
        busy_v[c] = busy;
        dat_v[c]  = out_data;
        if (out_valid && out_ready) acc.push_back(out_data);
    endtask

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; EN = 1'b1; start = 1'b0; len = 8'd0; flush = 1'b0; out_ready = 1'b1;
        #1 Rst = 1'b0;
        #2;
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", fifo_rd); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_dat: got %h want 0000", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        adv(); adv();
        Rst = 1'b1;
        adv();
    endtask

    task automatic test_basic();
        clr_rec();
        fpush(16'h0011); fpush(16'h0022); fpush(16'h0033); fpush(16'h0044);
        exp_w[0] = 16'h0011; exp_w[1] = 16'h0022; exp_w[2] = 16'h0033; exp_w[3] = 16'h0044;
        for (int c = 0; c < 9; c++) begin
            // second start at c=2 with len=1 must be ignored while busy
            start = (c == 0) || (c == 2);
            len   = (c == 2) ? 8'd1 : 8'd4;
            sample(c);
            adv();
        end
        start = 1'b0;
        checks++; if (rd_v[8:0] !== 9'h01E) begin errors++; $display("FAIL basic_rd: got %h want 01e", rd_v[8:0]); end
        checks++; if (vld_v[8:0] !== 9'h078) begin errors++; $display("FAIL basic_vld: got %h want 078", vld_v[8:0]); end
        checks++; if (done_v[8:0] !== 9'h080) begin errors++; $display("FAIL basic_done: got %h want 080", done_v[8:0]); end
        checks++; if (busy_v[8:0] !== 9'h0FE) begin errors++; $display("FAIL basic_busy: got %h want 0fe", busy_v[8:0]); end
        checks++; if (acc.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", acc.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc.size() <= i || acc[i] !== exp_w[i]) begin
                errors++; $display("FAIL basic_word%0d: got %h want %h", i, (acc.size() > i) ? acc[i] : 16'hxxxx, exp_w[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clr_rec();
        fpush(16'h0011); fpush(16'h0022); fpush(16'h0033);
        exp_w[0] = 16'h0011; exp_w[1] = 16'h0022; exp_w[2] = 16'h0033;
        for (int c = 0; c < 12; c++) begin
            start     = (c == 0);
            len       = 8'd3;
            out_ready = !(c >= 2 && c <= 6);
            sample(c);
            adv();
        end
        start = 1'b0; out_ready = 1'b1;
        checks++; if (rd_v[11:0] !== 12'h086) begin errors++; $display("FAIL bp_rd: got %h want 086", rd_v[11:0]); end
        checks++; if (vld_v[11:0] !== 12'h3F8) begin errors++; $display("FAIL bp_vld: got %h want 3f8", vld_v[11:0]); end
        checks++; if (done_v[11:0] !== 12'h400) begin errors++; $display("FAIL bp_done: got %h want 400", done_v[11:0]); end
        checks++; if (dat_v[4] !== 16'h0011) begin errors++; $display("FAIL bp_hold4: got %h want 0011", dat_v[4]); end
        checks++; if (dat_v[6] !== 16'h0011) begin errors++; $display("FAIL bp_hold6: got %h want 0011", dat_v[6]); end
        checks++; if (acc.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", acc.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc.size() <= i || acc[i] !== exp_w[i]) begin
                errors++; $display("FAIL bp_word%0d: got %h want %h", i, (acc.size() > i) ? acc[i] : 16'hxxxx, exp_w[i]);
            end
        end
    endtask

    task automatic test_empty_stall();
        clr_rec();
        fpush(16'h00A1);
        exp_w[0] = 16'h00A1; exp_w[1] = 16'h00A2; exp_w[2] = 16'h00A3;
        for (int c = 0; c < 11; c++) begin
            if (c == 5) begin fpush(16'h00A2); fpush(16'h00A3); end
            start = (c == 0);
            len   = 8'd3;
            sample(c);
            adv();
        end
        start = 1'b0;
        checks++; if (rd_v[10:0] !== 11'h062) begin errors++; $display("FAIL empty_rd: got %h want 062", rd_v[10:0]); end
        checks++; if (busy_v[10:0] !== 11'h3FE) begin errors++; $display("FAIL empty_busy: got %h want 3fe", busy_v[10:0]); end
        checks++; if (done_v[10:0] !== 11'h200) begin errors++; $display("FAIL empty_done: got %h want 200", done_v[10:0]); end
        checks++; if (acc.size() != 3) begin errors++; $display("FAIL empty_count: got %0d want 3", acc.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc.size() <= i || acc[i] !== exp_w[i]) begin
                errors++; $display("FAIL empty_word%0d: got %h want %h", i, (acc.size() > i) ? acc[i] : 16'hxxxx, exp_w[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        clr_rec();
        fpush(16'h00EE);
        for (int c = 0; c < 4; c++) begin
            start = (c == 0);
            len   = 8'd0;
            sample(c);
            adv();
        end
        checks++; if (rd_v[3:0] !== 4'h0) begin errors++; $display("FAIL zero_rd: got %h want 0", rd_v[3:0]); end
        checks++; if (done_v[3:0] !== 4'h2) begin errors++; $display("FAIL zero_done: got %h want 2", done_v[3:0]); end
        checks++; if (busy_v[3:0] !== 4'h2) begin errors++; $display("FAIL zero_busy: got %h want 2", busy_v[3:0]); end
        clr_rec();
        for (int c = 0; c < 6; c++) begin
            start = (c == 0);
            len   = 8'd1;
            sample(c);
            adv();
        end
        start = 1'b0;
        checks++; if (rd_v[5:0] !== 6'h02) begin errors++; $display("FAIL one_rd: got %h want 02", rd_v[5:0]); end
        checks++; if (done_v[5:0] !== 6'h10) begin errors++; $display("FAIL one_done: got %h want 10", done_v[5:0]); end
        checks++;
        if (acc.size() != 1 || acc[0] !== 16'h00EE) begin
            errors++; $display("FAIL one_word: got %0d words first %h want 1 word 00ee", acc.size(), (acc.size() > 0) ? acc[0] : 16'hxxxx);
        end
    endtask

    task automatic test_flush();
        clr_rec();
        for (int i = 0; i < 7; i++) fpush(16'h00B0 + 16'(i));
        for (int c = 0; c < 10; c++) begin
            start     = (c == 0);
            len       = 8'd8;
            flush     = (c == 6);
            out_ready = (c != 6);
            sample(c);
            adv();
        end
        start = 1'b0; flush = 1'b0; out_ready = 1'b1;
        checks++; if (rd_v[9:0] !== 10'h03E) begin errors++; $display("FAIL flush_rd: got %h want 03e", rd_v[9:0]); end
        checks++; if (busy_v[6] !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b want 1", busy_v[6]); end
        checks++; if (busy_v[7] !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b want 0", busy_v[7]); end
        checks++; if (vld_v[7] !== 1'b0) begin errors++; $display("FAIL flush_vld_after: got %b want 0", vld_v[7]); end
        checks++; if (done_v[9:0] !== 10'h000) begin errors++; $display("FAIL flush_nodone: got %h want 000", done_v[9:0]); end
        checks++;
        if (acc.size() != 3 || acc[0] !== 16'h00B0 || acc[2] !== 16'h00B2) begin
            errors++; $display("FAIL flush_pre_words: got %0d words want b0,b1,b2", acc.size());
        end
        clr_rec();
        for (int c = 0; c < 7; c++) begin
            start = (c == 0);
            len   = 8'd2;
            sample(c);
            adv();
        end
        start = 1'b0;
        checks++; if (done_v[6:0] !== 7'h20) begin errors++; $display("FAIL flush_restart_done: got %h want 20", done_v[6:0]); end
        checks++;
        if (acc.size() != 2 || acc[0] !== 16'h00B5 || acc[1] !== 16'h00B6) begin
            errors++; $display("FAIL flush_restart_words: got %0d words first %h want b5,b6", acc.size(), (acc.size() > 0) ? acc[0] : 16'hxxxx);
        end
    endtask

    task automatic test_en_gating();
        clr_rec();
        for (int i = 0; i < 6; i++) begin
            fpush(16'h00C0 + 16'(i));
            exp_w[i] = 16'h00C0 + 16'(i);
        end
        for (int c = 0; c < 14; c++) begin
            start = (c == 0);
            len   = 8'd6;
            EN    = !(c >= 4 && c <= 6);
            sample(c);
            adv();
        end
        start = 1'b0; EN = 1'b1;
        checks++; if (rd_v[13:0] !== 14'h038E) begin errors++; $display("FAIL en_rd: got %h want 038e", rd_v[13:0]); end
        checks++; if (vld_v[13:0] !== 14'h0F88) begin errors++; $display("FAIL en_vld: got %h want 0f88", vld_v[13:0]); end
        checks++; if (done_v[13:0] !== 14'h1000) begin errors++; $display("FAIL en_done: got %h want 1000", done_v[13:0]); end
        checks++; if (acc.size() != 6) begin errors++; $display("FAIL en_count: got %0d want 6", acc.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (acc.size() <= i || acc[i] !== exp_w[i]) begin
                errors++; $display("FAIL en_word%0d: got %h want %h", i, (acc.size() > i) ? acc[i] : 16'hxxxx, exp_w[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        clr_rec();
        fpush(16'h00D0); fpush(16'h00D1); fpush(16'h00D2); fpush(16'h00D3);
        for (int c = 0; c < 4; c++) begin
            start = (c == 0);
            len   = 8'd4;
            sample(c);
            adv();
        end
        start = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_busy_before: got %b want 1", busy); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_vld_before: got %b want 1", out_valid); end
        Rst = 1'b0;
        #1;
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL arst_rd: got %b want 0", fifo_rd); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_vld: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL arst_dat: got %h want 0000", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b want 0", done); end
        adv();
        Rst = 1'b1;
        adv();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_stall();
        test_zero_len();
        test_flush();
        test_en_gating();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
